// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// No logic; no latency.
// Imported by hazard_ctrl and fwd_unit.
package hazard_ctrl_pkg;

  // RUN: normal issue; MC_WAIT: holding a multi-cycle op in EX
  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand bypass select for one EX source register.
// Purely combinational, zero latency.
// No backpressure; MEM result wins over WB when both match.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_E,
  input  logic [4:0] rd_M,
  input  logic       we_M,
  input  logic [4:0] rd_W,
  input  logic       we_W,
  output logic [1:0] fwd
);

  // Youngest producer first; x0 is never forwarded
  always_comb begin
    fwd = FWD_RF;
    if (we_M && (rd_M != 5'd0) && (rd_M == rs_E)) begin
      fwd = FWD_MEM;
    end else if (we_W && (rd_W != 5'd0) && (rd_W == rs_E)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding, load-use stall, redirect flush, multi-cycle EX hold.
// Stall/flush/forward are same-cycle combinational; mc_last follows the final stall by one cycle.
// Stalls F/D (and E for multi-cycle ops); every output is held at 0 while rst_n is low.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             write_enable_RF_E,
  input  logic             write_back_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             write_enable_RF_M,
  input  logic             write_enable_RF_W,
  input  logic             mispredict_E,
  input  logic             mc_start_E,
  input  logic [MC_W-1:0]  mc_cycles_E,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       forwardA_E,
  output logic [1:0]       forwardB_E,
  output logic             mc_last,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t          state;
  logic [MC_W-1:0] cnt;
  logic            mc_done;   // op finishes EX this cycle after its stall window
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            load_use;
  logic            mc_req;
  logic            mc_multi;
  logic            mc_single;

  fwd_unit u_fwd_a (
    .rs_E (rs1_E),
    .rd_M (rd_M),
    .we_M (write_enable_RF_M),
    .rd_W (rd_W),
    .we_W (write_enable_RF_W),
    .fwd  (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs_E (rs2_E),
    .rd_M (rd_M),
    .we_M (write_enable_RF_M),
    .rd_W (rd_W),
    .we_W (write_enable_RF_W),
    .fwd  (fwd_b)
  );

  // Hazard detection; a multi-cycle op still in EX on its final cycle must not restart
  always_comb begin
    load_use  = write_back_E && write_enable_RF_E && (rd_E != 5'd0) &&
                ((rd_E == rs1_D) || (rd_E == rs2_D));
    mc_req    = mc_start_E && !mc_done;
    mc_multi  = mc_req && (mc_cycles_E >= MC_W'(2));
    mc_single = mc_req && (mc_cycles_E <= MC_W'(1));
  end

  // Stall/flush/forward decode, forced low during reset
  always_comb begin
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    mc_last    = 1'b0;
    forwardA_E = FWD_RF;
    forwardB_E = FWD_RF;
    if (rst_n) begin
      forwardA_E = fwd_a;
      forwardB_E = fwd_b;
      if (state == MC_WAIT) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else begin
        mc_last = mc_done || (!mispredict_E && mc_single);
        if (mispredict_E) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (mc_multi) begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
        end else if (load_use) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
    end
  end

  // Multi-cycle FSM: cnt holds the stall cycles still owed after the current one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      cnt     <= '0;
      mc_done <= 1'b0;
    end else begin
      mc_done <= 1'b0;
      case (state)
        RUN: begin
          if (!mispredict_E && mc_multi) begin
            if (mc_cycles_E > MC_W'(2)) begin
              state <= MC_WAIT;
              cnt   <= mc_cycles_E - MC_W'(2);
            end else begin
              mc_done <= 1'b1;
            end
          end
        end
        MC_WAIT: begin
          cnt <= cnt - MC_W'(1);
          if (cnt == MC_W'(1)) begin
            state   <= RUN;
            mc_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Saturating count of fetch-stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (StallF && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of single-cycle vectors plus multi-cycle sequences.
// A second instance with a 4-bit stall counter covers saturation.
// Outputs sampled 1ns after the falling edge, inputs driven on the falling edge.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic write_enable_RF_E, write_back_E, write_enable_RF_M, write_enable_RF_W;
  logic mispredict_E, mc_start_E;
  logic [4:0] mc_cycles_E;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_last;
  logic [1:0] forwardA_E, forwardB_E;
  logic [15:0] stall_cnt;
  logic s4_StallF, s4_StallD, s4_StallE, s4_FlushD, s4_FlushE, s4_FlushM, s4_mc_last;
  logic [1:0] s4_fa, s4_fb;
  logic [3:0] s4_stall_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .write_enable_RF_E(write_enable_RF_E), .write_back_E(write_back_E),
    .rd_M(rd_M), .rd_W(rd_W),
    .write_enable_RF_M(write_enable_RF_M), .write_enable_RF_W(write_enable_RF_W),
    .mispredict_E(mispredict_E), .mc_start_E(mc_start_E), .mc_cycles_E(mc_cycles_E),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .mc_last(mc_last), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.MC_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .write_enable_RF_E(write_enable_RF_E), .write_back_E(write_back_E),
    .rd_M(rd_M), .rd_W(rd_W),
    .write_enable_RF_M(write_enable_RF_M), .write_enable_RF_W(write_enable_RF_W),
    .mispredict_E(mispredict_E), .mc_start_E(mc_start_E), .mc_cycles_E(mc_cycles_E),
    .StallF(s4_StallF), .StallD(s4_StallD), .StallE(s4_StallE),
    .FlushD(s4_FlushD), .FlushE(s4_FlushE), .FlushM(s4_FlushM),
    .forwardA_E(s4_fa), .forwardB_E(s4_fb),
    .mc_last(s4_mc_last), .stall_cnt(s4_stall_cnt)
  );

  // {StallF,StallD,StallE,FlushD,FlushE,FlushM,forwardA_E,forwardB_E,mc_last}
  logic [10:0] obs;
  assign obs = {StallF, StallD, StallE, FlushD, FlushE, FlushM,
                forwardA_E, forwardB_E, mc_last};

  typedef struct {
    string       name;
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde;
    logic        wee, wbe;
    logic [4:0]  rdm;
    logic        wem;
    logic [4:0]  rdw;
    logic        wew, mis, mcs;
    logic [4:0]  mcn;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    write_enable_RF_E = 0; write_back_E = 0; write_enable_RF_M = 0; write_enable_RF_W = 0;
    mispredict_E = 0; mc_start_E = 0; mc_cycles_E = 0;
  endtask

  task automatic drive(input vec_t v);
    rs1_D = v.rs1d; rs2_D = v.rs2d; rs1_E = v.rs1e; rs2_E = v.rs2e; rd_E = v.rde;
    write_enable_RF_E = v.wee; write_back_E = v.wbe;
    rd_M = v.rdm; write_enable_RF_M = v.wem; rd_W = v.rdw; write_enable_RF_W = v.wew;
    mispredict_E = v.mis; mc_start_E = v.mcs; mc_cycles_E = v.mcn;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    #1;
    chk("reset_outputs", 32'(obs), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_use_inputs();
    idle();
    rd_E = 5; write_enable_RF_E = 1; write_back_E = 1; rs1_D = 5;
  endtask

  initial begin
    //             name            rs1d rs2d rs1e rs2e rde wee wbe rdm wem rdw wew mis mcs mcn exp
    vecs[0]  = '{"idle",           0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  11'b000000_00_00_0};
    vecs[1]  = '{"fwd_mem_prio",   0,   0,   3,   0,   0,  0,  0,  3,  1,  3,  1,  0,  0,  0,  11'b000000_10_00_0};
    vecs[2]  = '{"fwd_wb_rdm0",    0,   0,   3,   0,   0,  0,  0,  0,  1,  3,  1,  0,  0,  0,  11'b000000_01_00_0};
    vecs[3]  = '{"fwd_b_x0",       0,   0,   7,   0,   0,  0,  0,  7,  1,  0,  1,  0,  0,  0,  11'b000000_10_00_0};
    vecs[4]  = '{"fwd_b_wb",       0,   0,   0,   9,   0,  0,  0,  9,  0,  9,  1,  0,  0,  0,  11'b000000_00_01_0};
    vecs[5]  = '{"fwd_no_we",      0,   0,   4,   4,   0,  0,  0,  4,  0,  4,  0,  0,  0,  0,  11'b000000_00_00_0};
    vecs[6]  = '{"load_use_rs2",   0,   6,   0,   0,   6,  1,  1,  0,  0,  0,  0,  0,  0,  0,  11'b110010_00_00_0};
    vecs[7]  = '{"load_rd0",       0,   0,   0,   0,   0,  1,  1,  0,  0,  0,  0,  0,  0,  0,  11'b000000_00_00_0};
    vecs[8]  = '{"not_load",       6,   0,   0,   0,   6,  1,  0,  0,  0,  0,  0,  0,  0,  0,  11'b000000_00_00_0};
    vecs[9]  = '{"mispredict",     0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  11'b000110_00_00_0};
    vecs[10] = '{"mis_lu_mc4",     5,   0,   0,   0,   5,  1,  1,  0,  0,  0,  0,  1,  1,  4,  11'b000110_00_00_0};
    vecs[11] = '{"mc_single_n1",   0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  0,  0,  1,  1,  11'b000000_00_00_1};
    vecs[12] = '{"mc_single_n0",   0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  11'b000000_00_00_1};
    vecs[13] = '{"idle_after",     0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  11'b000000_00_00_0};

    idle();
    rst_n = 1'b0;
    do_reset();

    // Single-cycle vectors
    for (int i = 0; i < 14; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      chk(vecs[i].name, 32'(obs), 32'(vecs[i].exp));
    end

    // Load-use: one stall cycle, counted once
    do_reset();
    load_use_inputs();
    #1;
    chk("lu_cycle1", 32'(obs), 32'(11'b110010_00_00_0));
    @(negedge clk);
    idle();
    #1;
    chk("lu_cycle2", 32'(obs), 32'd0);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Multi-cycle N=4 with mc_start held while the op sits in EX
    do_reset();
    idle();
    mc_start_E = 1; mc_cycles_E = 4;
    for (int c = 1; c <= 4; c++) begin
      if (c != 1) @(negedge clk);
      #1;
      if (c < 4) chk($sformatf("mc4_stall_c%0d", c), 32'(obs), 32'(11'b111001_00_00_0));
      else       chk("mc4_last", 32'(obs), 32'(11'b000000_00_00_1));
    end
    @(negedge clk);
    idle();
    #1;
    chk("mc4_done_idle", 32'(obs), 32'd0);
    chk("mc4_stall_cnt", 32'(stall_cnt), 32'd3);

    // Multi-cycle N=2 stays in RUN: one stall then mc_last
    @(negedge clk);
    mc_start_E = 1; mc_cycles_E = 2;
    #1;
    chk("mc2_stall", 32'(obs), 32'(11'b111001_00_00_0));
    @(negedge clk);
    #1;
    chk("mc2_last", 32'(obs), 32'(11'b000000_00_00_1));
    @(negedge clk);
    idle();
    #1;
    chk("mc2_stall_cnt", 32'(stall_cnt), 32'd4);

    // Reset asserted on the second MC_WAIT cycle
    do_reset();
    idle();
    mc_start_E = 1; mc_cycles_E = 6;
    #1;
    chk("mr_run_stall", 32'(obs), 32'(11'b111001_00_00_0));
    @(negedge clk);
    #1;
    chk("mr_wait1", 32'(obs), 32'(11'b111001_00_00_0));
    @(negedge clk);
    rs1_E = 3; rd_M = 3; write_enable_RF_M = 1;
    #1;
    chk("mr_wait2", 32'(obs), 32'(11'b111001_10_00_0));
    rst_n = 1'b0;
    #1;
    chk("mr_outputs_zero", 32'(obs), 32'd0);
    chk("mr_cnt_zero", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("mr_post_c%0d", c), 32'(obs), 32'd0);
      @(negedge clk);
    end
    chk("mr_post_cnt", 32'(stall_cnt), 32'd0);

    // 20 continuous load-use stalls: 4-bit counter saturates at 15
    do_reset();
    load_use_inputs();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      #1;
      if (i == 15) chk("sat_reach15", 32'(s4_stall_cnt), 32'd15);
    end
    chk("sat_hold15", 32'(s4_stall_cnt), 32'd15);
    chk("sat_wide20", 32'(stall_cnt), 32'd20);
    idle();
    @(negedge clk);
    #1;
    chk("sat_after_idle", 32'(s4_stall_cnt), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
